// File: rtl/uart_tx_fifo_if.sv
// Push-side bus between the memory map and the UART transmitter.
// The memory map drives a byte together with a single-cycle request strobe.
// There is no backpressure signal: the transmitter either stores the byte or
// drops it and flags an overflow.
//
// Signals:
//   uart_tx_data  8  byte to send, meaningful only while uart_tx_req = 1
//   uart_tx_req   1  push strobe, one byte per cycle it is high
//
// Modports:
//   master  memory-map side (drives data and request)
//   slave   transmitter side (samples data and request)

interface uart_tx_fifo_if;
    logic [7:0] uart_tx_data;
    logic       uart_tx_req;

    modport master (output uart_tx_data, output uart_tx_req);
    modport slave  (input  uart_tx_data, input  uart_tx_req);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Bytes pushed by the memory map are queued in a FIFO and shifted out LSB
// first on txd, framed by one start bit (0) and one stop bit (1). Frames run
// back to back with no idle cycle when the FIFO still holds data.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit, >= 2
//   FIFO_DEPTH    FIFO entries, power of two, >= 2
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   tx_bus          push bus (uart_tx_data, uart_tx_req), slave side
//   clear_overflow  clears the sticky overflow flag
//   txd             registered serial output, idle high
//   tx_busy         high while a frame is on the line or bytes are queued
//   fifo_count      bytes waiting, excluding the byte being shifted
//   overflow        sticky: a push was dropped because the FIFO was full

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 496,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_fifo_if.slave                 tx_bus,
    input  logic                          clear_overflow,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             txd_next;
    logic             busy_next;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             fifo_empty;
    logic             pop;
    logic             push;

    assign fifo_empty = (fifo_count == '0);

    // Transmit FSM. The timer counts down the cycles left in the current bit;
    // txd is registered, so txd_next is the line level for the state being
    // entered. Popping on the last stop cycle gives gap-free back-to-back frames.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        txd_next     = 1'b1;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    timer_next = TMR_LOAD;
                    state_next = START;
                    txd_next   = 1'b0;
                end
            end

            START: begin
                txd_next = 1'b0;
                if (timer == '0) begin
                    state_next   = DATA;
                    timer_next   = TMR_LOAD;
                    bit_idx_next = '0;
                    txd_next     = shift[0];
                end else begin
                    timer_next = timer - 1'b1;
                end
            end

            DATA: begin
                txd_next = shift[0];
                if (timer == '0) begin
                    timer_next = TMR_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = {1'b0, shift[7:1]};
                        txd_next     = shift[1];
                    end
                end else begin
                    timer_next = timer - 1'b1;
                end
            end

            STOP: begin
                txd_next = 1'b1;
                if (timer == '0) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        timer_next = TMR_LOAD;
                        state_next = START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A push into a full FIFO is still accepted when a pop frees a slot at
    // the same edge. Fullness comes from the count, never from pointers.
    always_comb begin
        push       = tx_bus.uart_tx_req && ((fifo_count != FULL_COUNT) || pop);
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + 1'b1;
            2'b01:   count_next = fifo_count - 1'b1;
            default: count_next = fifo_count;
        endcase
        busy_next = (state_next != IDLE) || (count_next != '0);
    end

    // Control and status registers. Overflow set takes priority over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            txd        <= txd_next;
            tx_busy    <= busy_next;
            fifo_count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (tx_bus.uart_tx_req && !push) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // FIFO storage has no reset; the count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= tx_bus.uart_tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// A queue-based model predicts txd, tx_busy, fifo_count and overflow every
// cycle; a line decoder rebuilds the transmitted bytes from txd; directed
// scenarios pin exact edge timing with literal values.

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_overflow;
    logic       txd;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       overflow;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_bus        (bus),
        .clear_overflow(clear_overflow),
        .txd           (txd),
        .tx_busy       (tx_busy),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    bit check_en = 1'b0;

    // Reference model: a byte queue plus the position inside the current frame.
    logic [7:0] mq[$];
    logic [7:0] popped[$];
    int         frame_t = -1;
    logic [7:0] cur     = 8'h00;
    bit         m_ovf   = 1'b0;
    bit         m_pop;
    bit         m_acc;

    logic [7:0] rx_q[$];
    logic [7:0] burst[18];
    int         t2_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit req, input logic [7:0] data, input bit clr);
        bus.uart_tx_req  = req;
        bus.uart_tx_data = data;
        clear_overflow   = clr;
        @(posedge clk);
        #1;
        bus.uart_tx_req  = 1'b0;
        bus.uart_tx_data = 8'($urandom);
        clear_overflow   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'($urandom), 1'b0);
        end
    endtask

    function automatic logic [31:0] rxAt(input int i);
        if (i < rx_q.size()) begin
            return 32'(rx_q[i]);
        end
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic expTxd();
        int b;
        if (frame_t < 0) begin
            return 1'b1;
        end
        b = frame_t / CPB;
        if (b == 0) begin
            return 1'b0;
        end
        if (b == 9) begin
            return 1'b1;
        end
        return cur[b-1];
    endfunction

    // Model update: pop when idle or at the end of a frame, then accept the
    // push if there is room (room includes a slot freed by this edge's pop).
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            frame_t = -1;
            m_ovf   = 1'b0;
        end else begin
            m_pop = (mq.size() > 0) && ((frame_t < 0) || (frame_t == FRAME - 1));
            m_acc = bus.uart_tx_req && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) begin
                cur = mq.pop_front();
                popped.push_back(cur);
                frame_t = 0;
            end else if (frame_t == FRAME - 1) begin
                frame_t = -1;
            end else if (frame_t >= 0) begin
                frame_t++;
            end
            if (m_acc) begin
                mq.push_back(bus.uart_tx_data);
            end
            if (bus.uart_tx_req && !m_acc) begin
                m_ovf = 1'b1;
            end else if (clear_overflow) begin
                m_ovf = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_txd", 32'(txd), 32'(expTxd()));
            checkOutput("model_tx_busy", 32'(tx_busy), 32'((frame_t >= 0) || (mq.size() != 0)));
            checkOutput("model_fifo_count", 32'(fifo_count), 32'(mq.size()));
            checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // Line decoder: find a start bit, sample each bit in its middle.
    initial begin : receiver
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    b[k] = txd;
                    if (k < 7) begin
                        repeat (CPB) @(negedge clk);
                    end
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        reset            = 1'b1;
        clear_overflow   = 1'b0;
        bus.uart_tx_req  = 1'b0;
        bus.uart_tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        check_en = 1'b1;

        $display("[TB] reset and idle");
        idle(100);
        checkOutput("t1_txd", 32'(txd), 32'h1);
        checkOutput("t1_busy", 32'(tx_busy), 32'h0);
        checkOutput("t1_count", 32'(fifo_count), 32'h0);
        checkOutput("t1_overflow", 32'(overflow), 32'h0);

        $display("[TB] single byte 0xA5");
        rx_q.delete();
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("t2_count_after_push", 32'(fifo_count), 32'h1);
        checkOutput("t2_txd_after_push", 32'(txd), 32'h1);
        checkOutput("t2_busy_after_push", 32'(tx_busy), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t2_txd_start", 32'(txd), 32'h0);
        checkOutput("t2_count_after_pop", 32'(fifo_count), 32'h0);
        for (int i = 0; i < FRAME; i++) begin
            checkOutput("t2_frame_bit", 32'(txd), 32'(t2_bits[i / CPB]));
            if (i == FRAME - 1) begin
                checkOutput("t2_busy_last", 32'(tx_busy), 32'h1);
            end
            applyStimulus(1'b0, 8'($urandom), 1'b0);
        end
        checkOutput("t2_busy_drop", 32'(tx_busy), 32'h0);
        checkOutput("t2_txd_idle", 32'(txd), 32'h1);
        idle(10);
        checkOutput("t2_rx_count", 32'(rx_q.size()), 32'd1);
        checkOutput("t2_rx0", rxAt(0), 32'hA5);

        $display("[TB] back-to-back 0x55, 0x0F");
        rx_q.delete();
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("t3_count_a", 32'(fifo_count), 32'h1);
        applyStimulus(1'b1, 8'h0F, 1'b0);
        checkOutput("t3_count_b", 32'(fifo_count), 32'h1);
        checkOutput("t3_first_start", 32'(txd), 32'h0);
        idle(FRAME - 1);
        checkOutput("t3_last_stop", 32'(txd), 32'h1);
        checkOutput("t3_count_before", 32'(fifo_count), 32'h1);
        idle(1);
        checkOutput("t3_second_start", 32'(txd), 32'h0);
        checkOutput("t3_count_c", 32'(fifo_count), 32'h0);
        idle(FRAME + 10);
        checkOutput("t3_rx_count", 32'(rx_q.size()), 32'd2);
        checkOutput("t3_rx0", rxAt(0), 32'h55);
        checkOutput("t3_rx1", rxAt(1), 32'h0F);

        $display("[TB] 18-push burst");
        rx_q.delete();
        for (int i = 0; i < 18; i++) begin
            burst[i] = 8'($urandom);
            applyStimulus(1'b1, burst[i], 1'b0);
        end
        checkOutput("t4_overflow", 32'(overflow), 32'h1);
        checkOutput("t4_count", 32'(fifo_count), 32'd16);
        idle(17 * FRAME + 20);
        checkOutput("t4_rx_count", 32'(rx_q.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            checkOutput("t4_rx_byte", rxAt(i), 32'(burst[i]));
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4_overflow_cleared", 32'(overflow), 32'h0);

        $display("[TB] push into full FIFO at a pop edge");
        rx_q.delete();
        for (int i = 0; i < 17; i++) begin
            burst[i] = 8'($urandom);
            applyStimulus(1'b1, burst[i], 1'b0);
        end
        checkOutput("t5_count_full", 32'(fifo_count), 32'd16);
        idle(24);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        checkOutput("t5_count_at_pop", 32'(fifo_count), 32'd16);
        checkOutput("t5_overflow_at_pop", 32'(overflow), 32'h0);
        applyStimulus(1'b1, 8'hC3, 1'b1);
        checkOutput("t5_set_beats_clear", 32'(overflow), 32'h1);
        checkOutput("t5_count_after_drop", 32'(fifo_count), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t5_overflow_cleared", 32'(overflow), 32'h0);
        idle(17 * FRAME + 20);
        checkOutput("t5_busy_drained", 32'(tx_busy), 32'h0);
        checkOutput("t5_rx_count", 32'(rx_q.size()), 32'd18);
        for (int i = 0; i < 17; i++) begin
            checkOutput("t5_rx_byte", rxAt(i), 32'(burst[i]));
        end
        checkOutput("t5_rx_last", rxAt(17), 32'h3C);

        $display("[TB] reset during DATA");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0);
        end
        idle(10);
        checkOutput("t6_count_before", 32'(fifo_count), 32'd5);
        checkOutput("t6_busy_before", 32'(tx_busy), 32'h1);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        checkOutput("t6_txd", 32'(txd), 32'h1);
        checkOutput("t6_count", 32'(fifo_count), 32'h0);
        checkOutput("t6_busy", 32'(tx_busy), 32'h0);
        for (int i = 0; i < 100; i++) begin
            checkOutput("t6_quiet", 32'(txd), 32'h1);
            applyStimulus(1'b0, 8'($urandom), 1'b0);
        end

        $display("[TB] randomized traffic");
        rx_q.delete();
        popped.delete();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                for (int k = 0; k < 20; k++) begin
                    applyStimulus(1'b1, 8'($urandom), $urandom_range(0, 9) == 0);
                end
            end else begin
                applyStimulus($urandom_range(0, 99) < 3, 8'($urandom), $urandom_range(0, 99) == 0);
            end
        end
        idle(17 * FRAME + 50);
        checkOutput("rand_busy_drained", 32'(tx_busy), 32'h0);
        checkOutput("rand_rx_count", 32'(rx_q.size()), 32'(popped.size()));
        for (int i = 0; i < popped.size(); i++) begin
            checkOutput("rand_rx_byte", rxAt(i), 32'(popped[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
